// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/freeze controller: state codes,
// register-address width and the load-use hazard predicate.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_W = 5;

  typedef logic [REG_W-1:0] reg_addr_t;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  // A load in EX feeding either ID source; x0 never creates a dependency.
  function automatic logic load_use_hazard(input logic      mem_read,
                                           input reg_addr_t rd,
                                           input reg_addr_t rs1,
                                           input reg_addr_t rs2);
    return mem_read && (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
module pipeline_ctrl_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory-wait
// freeze with timeout-to-halt, and saturating stall/flush counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] ID_Rs1_i,
  input  logic [REG_W-1:0] ID_Rs2_i,
  input  logic [REG_W-1:0] EX_Rd_i,
  input  logic             EX_MemRead_i,
  input  logic             ID_BranchTaken_i,
  input  logic             MEM_Req_i,
  input  logic             MEM_Ack_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             NoOp_o,
  output logic             Flush_o,
  output logic             Freeze_o,
  output logic             Halt_o,
  output logic [CNT_W-1:0] StallCnt_o,
  output logic [CNT_W-1:0] FlushCnt_o
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] wait_cnt;
  logic       load_use;
  logic       mem_stall;
  logic       mem_done;
  logic       stall_inc;
  logic       flush_inc;

  assign load_use  = load_use_hazard(EX_MemRead_i, EX_Rd_i, ID_Rs1_i, ID_Rs2_i);
  assign mem_stall = MEM_Req_i && !MEM_Ack_i;
  // An acknowledge only counts when a request is actually outstanding.
  assign mem_done  = MEM_Req_i && MEM_Ack_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_stall) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_done) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= ST_HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  assign Halt_o = (state == ST_HALT);

  always_comb begin
    Freeze_o    = (state == ST_HALT) || mem_stall;
    PCWrite_o   = 1'b1;
    IFIDWrite_o = 1'b1;
    NoOp_o      = 1'b0;
    Flush_o     = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (Freeze_o) begin
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
    end else if (load_use) begin
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      NoOp_o      = 1'b1;
      stall_inc   = 1'b1;
    end else if (ID_BranchTaken_i) begin
      Flush_o   = 1'b1;
      flush_inc = 1'b1;
    end
  end

  pipeline_ctrl_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (stall_inc),
    .clear (1'b0),
    .count (StallCnt_o)
  );

  pipeline_ctrl_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (flush_inc),
    .clear (1'b0),
    .count (FlushCnt_o)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized and directed bench for pipeline_ctrl against a behavioural model;
// a second instance with 4-bit counters exercises saturation.
module tb_pipeline_ctrl;

  localparam int unsigned TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       mem_read, branch, req, ack;

  logic       pcw_a, ifid_a, noop_a, flush_a, freeze_a, halt_a;
  logic [15:0] stallcnt_a, flushcnt_a;
  logic       pcw_b, ifid_b, noop_b, flush_b, freeze_b, halt_b;
  logic [3:0] stallcnt_b, flushcnt_b;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state
  bit m_halted, m_waiting;
  int m_elapsed, m_stalls, m_flushes;

  always #5 clk = ~clk;

  pipeline_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .ID_Rs1_i(rs1), .ID_Rs2_i(rs2), .EX_Rd_i(rd),
    .EX_MemRead_i(mem_read), .ID_BranchTaken_i(branch), .MEM_Req_i(req), .MEM_Ack_i(ack),
    .PCWrite_o(pcw_a), .IFIDWrite_o(ifid_a), .NoOp_o(noop_a), .Flush_o(flush_a),
    .Freeze_o(freeze_a), .Halt_o(halt_a), .StallCnt_o(stallcnt_a), .FlushCnt_o(flushcnt_a)
  );

  pipeline_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .ID_Rs1_i(rs1), .ID_Rs2_i(rs2), .EX_Rd_i(rd),
    .EX_MemRead_i(mem_read), .ID_BranchTaken_i(branch), .MEM_Req_i(req), .MEM_Ack_i(ack),
    .PCWrite_o(pcw_b), .IFIDWrite_o(ifid_b), .NoOp_o(noop_b), .Flush_o(flush_b),
    .Freeze_o(freeze_b), .Halt_o(halt_b), .StallCnt_o(stallcnt_b), .FlushCnt_o(flushcnt_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int n, input int w);
    int top;
    top = (1 << w) - 1;
    return (n > top) ? top : n;
  endfunction

  // Drives one cycle of inputs (called at posedge+1), checks, advances model.
  task automatic cycle(input bit r, input bit mr, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input bit br, input bit rq, input bit ak);
    bit lu, frz;
    logic [5:0] exp_ctl;
    rst = r; mem_read = mr; rd = d; rs1 = s1; rs2 = s2; branch = br; req = rq; ack = ak;
    if (r) begin
      m_halted = 0; m_waiting = 0; m_elapsed = 0; m_stalls = 0; m_flushes = 0;
    end
    #2;
    lu  = mr && (d != 0) && ((d == s1) || (d == s2));
    frz = m_halted || (rq && !ak);
    // {PCWrite, IFIDWrite, NoOp, Flush, Freeze, Halt}
    if (frz)     exp_ctl = {4'b0000, 1'b1, m_halted};
    else if (lu) exp_ctl = 6'b001000;
    else if (br) exp_ctl = 6'b110100;
    else         exp_ctl = 6'b110000;
    check("ctl_a",   {pcw_a, ifid_a, noop_a, flush_a, freeze_a, halt_a}, exp_ctl);
    check("ctl_b",   {pcw_b, ifid_b, noop_b, flush_b, freeze_b, halt_b}, exp_ctl);
    check("stall_a", stallcnt_a, sat(m_stalls, 16));
    check("flush_a", flushcnt_a, sat(m_flushes, 16));
    check("stall_b", stallcnt_b, sat(m_stalls, 4));
    check("flush_b", flushcnt_b, sat(m_flushes, 4));
    if (!r) begin
      if (!frz && lu) m_stalls++;
      if (!frz && !lu && br) m_flushes++;
      if (!m_halted) begin
        if (!m_waiting) begin
          if (rq && !ak) begin m_waiting = 1; m_elapsed = 1; end
        end else if (rq && ak) begin
          m_waiting = 0; m_elapsed = 0;
        end else if (m_elapsed == TIMEOUT - 1) begin
          m_halted = 1;
        end else begin
          m_elapsed++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit r);
    cycle(r, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; mem_read = 0; rd = 0; rs1 = 0; rs2 = 0; branch = 0; req = 0; ack = 0;
    m_halted = 0; m_waiting = 0; m_elapsed = 0; m_stalls = 0; m_flushes = 0;
    @(posedge clk); #1;
    idle(1); idle(0);

    // Load-use on rs2 stalls and counts once
    cycle(0, 1, 5'd5, 5'd0, 5'd5, 0, 0, 0);
    idle(0);
    check("lu_count", stallcnt_a, 32'd1);

    // Destination x0 never stalls
    idle(1);
    cycle(0, 1, 5'd0, 5'd0, 5'd5, 0, 0, 0);
    idle(0);
    check("x0_count", stallcnt_a, 32'd0);

    // Branch under load-use is deferred, then taken
    idle(1);
    cycle(0, 1, 5'd7, 5'd7, 5'd1, 1, 0, 0);
    cycle(0, 0, 5'd7, 5'd7, 5'd1, 1, 0, 0);
    idle(0);
    check("br_count", flushcnt_a, 32'd1);

    // Three-cycle memory wait; branches during freeze are not counted
    idle(1);
    repeat (3) cycle(0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0);
    cycle(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
    idle(0);
    check("frz_flush", flushcnt_a, 32'd0);
    check("frz_halt", halt_a, 32'd0);

    // Memory timeout to halt, then asynchronous reset out of halt
    idle(1);
    cycle(0, 1, 5'd3, 5'd3, 5'd0, 0, 0, 0);
    repeat (TIMEOUT - 1) cycle(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    check("pre_halt", halt_a, 32'd0);
    cycle(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    check("halt_set", halt_a, 32'd1);
    repeat (2) cycle(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    idle(1);
    check("halt_clr", halt_a, 32'd0);
    check("cnt_clr", stallcnt_a, 32'd0);
    idle(0);

    // Saturation of the narrow counter
    repeat (20) cycle(0, 1, 5'd9, 5'd9, 5'd2, 0, 0, 0);
    check("sat_b", stallcnt_b, 32'd15);
    check("nosat_a", stallcnt_a, 32'd20);

    // Random traffic with narrow register range to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) < 2),
            ($urandom_range(0, 1) == 1),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 9) < 4),
            ($urandom_range(0, 9) < 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
